// File: rtl/video_scan_doubler_if.sv
// Source-side video and VGA-side output signals of the scan doubler.
interface video_scan_doubler_if;
    logic        MCKR;
    logic        HBLANK_b;
    logic        VBLANK_b;
    logic        VSYNC;
    logic [15:0] VIDOUT;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        VGA_HS_b;
    logic        VGA_VS_b;
    logic        VGA_DE;
    logic        OVERRUN;

    // Graphics side / environment: drives the source video, watches the VGA output.
    modport master (
        output MCKR, HBLANK_b, VBLANK_b, VSYNC, VIDOUT,
        input  VGA_R, VGA_G, VGA_B, VGA_HS_b, VGA_VS_b, VGA_DE, OVERRUN
    );

    // Scan doubler side.
    modport slave (
        input  MCKR, HBLANK_b, VBLANK_b, VSYNC, VIDOUT,
        output VGA_R, VGA_G, VGA_B, VGA_HS_b, VGA_VS_b, VGA_DE, OVERRUN
    );
endinterface

// File: rtl/video_scan_doubler.sv
// Scan doubler: captures one source line of IRGB pixels into a ping-pong line
// buffer and replays the last completed line twice per source line (31 kHz).
module video_scan_doubler #(
    parameter int H_ACTIVE     = 336,
    parameter int PIX_DIV      = 6,
    parameter int HS_LEN       = 380,
    parameter int H_START      = 600,
    parameter int DEFAULT_HALF = 3182
) (
    input  logic                clk,
    input  logic                rst_b,
    video_scan_doubler_if.slave vid
);

    localparam int AW = $clog2(H_ACTIVE + 1);
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [AW-1:0] LINE_LEN  = AW'(H_ACTIVE);
    localparam logic [DW-1:0] DIV_LAST  = DW'(PIX_DIV - 1);
    localparam logic [15:0]   HS_END    = 16'(HS_LEN);
    localparam logic [15:0]   WIN_START = 16'(H_START);
    localparam logic [15:0]   WIN_END   = 16'(H_START + H_ACTIVE * PIX_DIV);
    localparam logic [15:0]   HALF_RST  = 16'(DEFAULT_HALF);

    // Registered source inputs and their previous values for edge detection.
    logic mckr_q, mckr_qq, hblank_q, hblank_qq, vblank_q, vsync_q, vsync_qq;
    logic pix_stb, cap_stb, hb_rise, hb_fall, vs_rise;

    // Capture side.
    logic          wbank;
    logic [1:0]    bank_valid;
    logic [AW-1:0] waddr;
    logic [15:0]   line_buf [2][H_ACTIVE];

    // Line measurement and output timing.
    logic [15:0]   lc, lc_meas, half_meas, half_p, oc;
    logic          in_win;
    logic [DW-1:0] pdiv;
    logic [AW-1:0] raddr;

    // Pipeline stage 1.
    logic [15:0]   rd_data;
    logic          de_d1, hs_d1, vs_d1;

    assign pix_stb   = mckr_q & ~mckr_qq;
    assign cap_stb   = pix_stb & hblank_q & vblank_q;
    assign hb_rise   = hblank_q & ~hblank_qq;
    assign hb_fall   = ~hblank_q & hblank_qq;
    assign vs_rise   = vsync_q & ~vsync_qq;
    // Length of the previous source line in clk, saturating.
    assign lc_meas   = (lc == 16'hFFFF) ? lc : lc + 16'd1;
    assign half_meas = {1'b0, lc_meas[15:1]};
    assign in_win    = (oc >= WIN_START) && (oc < WIN_END) && (oc < half_p);

    // channel8 = c4 * (I4 + 1); fits in 8 bits (max 240).
    function automatic logic [7:0] scale(input logic [3:0] c, input logic [3:0] i);
        logic [8:0] prod;
        prod = {5'd0, c} * ({5'd0, i} + 9'd1);
        return prod[7:0];
    endfunction

    // Register the asynchronous source signals once and keep one more stage for edges.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mckr_q    <= 1'b0;
            mckr_qq   <= 1'b0;
            hblank_q  <= 1'b0;
            hblank_qq <= 1'b0;
            vblank_q  <= 1'b0;
            vsync_q   <= 1'b0;
            vsync_qq  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage see last cycle's value.
            mckr_q    <= vid.MCKR;
            mckr_qq   <= mckr_q;
            hblank_q  <= vid.HBLANK_b;
            hblank_qq <= hblank_q;
            vblank_q  <= vid.VBLANK_b;
            vsync_q   <= vid.VSYNC;
            vsync_qq  <= vsync_q;
        end
    end

    // Capture: fill the write bank, swap banks at the end of each active line.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wbank       <= 1'b0;
            bank_valid  <= 2'b00;
            waddr       <= '0;
            vid.OVERRUN <= 1'b0;
        end else begin
            if (hb_fall) begin
                // Lines ending inside vertical blank replay as black.
                bank_valid[wbank] <= vblank_q;
                wbank             <= ~wbank;
                waddr             <= '0;
            end else if (cap_stb && (waddr < LINE_LEN)) begin
                waddr <= waddr + 1'b1;
            end
            if (vs_rise) begin
                vid.OVERRUN <= 1'b0;
            end else if (cap_stb && (waddr >= LINE_LEN)) begin
                vid.OVERRUN <= 1'b1;
            end
        end
    end

    // Line buffer write and read ports; the read side always uses the completed bank.
    // NOTE: the line RAM has no reset; bank_valid keeps stale contents off the screen.
    always_ff @(posedge clk) begin
        if (cap_stb && (waddr < LINE_LEN)) begin
            line_buf[wbank][waddr] <= vid.VIDOUT;
        end
        rd_data <= line_buf[~wbank][raddr];
    end

    // Measure the source line period; implausibly short lines keep the old half period.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lc     <= '0;
            half_p <= HALF_RST;
        end else if (hb_rise) begin
            lc <= '0;
            if (half_meas >= WIN_END) begin
                half_p <= half_meas;
            end
        end else if (lc != 16'hFFFF) begin
            lc <= lc + 16'd1;
        end
    end

    // Output line counter and pixel divider; two output lines per source line.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            oc    <= '0;
            pdiv  <= '0;
            raddr <= '0;
        end else begin
            if (hb_rise || (oc == half_p - 16'd1)) begin
                oc <= '0;
            end else begin
                oc <= oc + 16'd1;
            end
            if (!in_win) begin
                pdiv  <= '0;
                raddr <= '0;
            end else if (pdiv == DIV_LAST) begin
                pdiv  <= '0;
                raddr <= raddr + 1'b1;
            end else begin
                pdiv <= pdiv + 1'b1;
            end
        end
    end

    // Two-stage output pipeline: RAM read alongside syncs, then colour convert.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            de_d1        <= 1'b0;
            hs_d1        <= 1'b0;
            vs_d1        <= 1'b0;
            vid.VGA_DE   <= 1'b0;
            vid.VGA_HS_b <= 1'b1;
            vid.VGA_VS_b <= 1'b1;
            vid.VGA_R    <= '0;
            vid.VGA_G    <= '0;
            vid.VGA_B    <= '0;
        end else begin
            de_d1        <= in_win & bank_valid[~wbank];
            hs_d1        <= (oc < HS_END);
            vs_d1        <= vsync_q;
            vid.VGA_DE   <= de_d1;
            vid.VGA_HS_b <= ~hs_d1;
            vid.VGA_VS_b <= ~vs_d1;
            vid.VGA_R    <= de_d1 ? scale(rd_data[11:8], rd_data[15:12]) : 8'd0;
            vid.VGA_G    <= de_d1 ? scale(rd_data[7:4],  rd_data[15:12]) : 8'd0;
            vid.VGA_B    <= de_d1 ? scale(rd_data[3:0],  rd_data[15:12]) : 8'd0;
        end
    end

endmodule
